// File: rtl/decoder_scan.sv
// One-hot decoder with DIRECT and SCAN modes.
// SCAN walks the indices from a captured start, holding each for DWELL enabled cycles.
module decoder_scan #(
    parameter int N     = 4,
    parameter int DWELL = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] d,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int W = 2 ** N;

    localparam logic [1:0] ST_DIRECT = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    logic [1:0]   state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [N-1:0] idx_nx;
    logic [W-1:0] d_nx;
    logic         wrap_nx;

    // MSB-first: index 0 lights the top bit
    function automatic logic [W-1:0] onehot(input logic [N-1:0] k);
        return {1'b1, {(W-1){1'b0}}} >> k;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        wrap_nx  = 1'b0;
        d_nx     = '0;
        if (state == ST_DIRECT || !mode) begin
            state_nx = mode ? ST_LOAD : ST_DIRECT;
            idx_nx   = sel;
            cnt_nx   = '0;
            d_nx     = enable ? onehot(sel) : '0;
        end else begin
            // Load and run count identically so the start index gets a full dwell
            state_nx = ST_RUN;
            if (enable) begin
                if (cnt == CNT_LAST) begin
                    cnt_nx  = '0;
                    idx_nx  = idx + N'(1);
                    wrap_nx = (idx == '1);
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
                d_nx = onehot(idx_nx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_DIRECT;
            cnt   <= '0;
            idx   <= '0;
            d     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            d     <= d_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (N=4, DWELL=3).
// Vector table plus hand-written reset sequences, checked through a scoreboard queue.
module tb_decoder_scan;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         mode;
    logic [N-1:0] sel;
    logic [W-1:0] d;
    logic [N-1:0] idx;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         en;
        logic         md;
        logic [N-1:0] s;
        logic [W-1:0] ed;
        logic [N-1:0] ei;
        logic         ew;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] ed;
        logic [N-1:0] ei;
        logic         ew;
        string        name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    decoder_scan #(.N(N), .DWELL(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .sel    (sel),
        .d      (d),
        .idx    (idx),
        .wrap   (wrap)
    );

    function automatic logic [W-1:0] oh(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int b = 0; b < W; b++)
            if (b == W - 1 - k) v[b] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic en, input logic md,
                                input int s, input logic [W-1:0] ed,
                                input int ei, input logic ew,
                                input string name);
        vec_t v;
        v.en = en;
        v.md = md;
        v.s = N'(s);
        v.ed = ed;
        v.ei = N'(ei);
        v.ew = ew;
        v.name = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        enable = v.en;
        mode = v.md;
        sel = v.s;
        sb.push_back('{v.ed, v.ei, v.ew, v.name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".d"}, d, e.ed);
            chk({e.name, ".idx"}, W'(idx), W'(e.ei));
            chk({e.name, ".wrap"}, W'(wrap), W'(e.ew));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(1, 0, 0, 16'b1000000000000000, 0, 0, "dir_s0"));
        vecs.push_back(mk(1, 0, 3, 16'b0001000000000000, 3, 0, "dir_s3"));
        vecs.push_back(mk(0, 0, 5, 16'b0, 5, 0, "blank"));
        vecs.push_back(mk(1, 0, 5, 16'b0000010000000000, 5, 0, "unblank"));
        vecs.push_back(mk(1, 1, 14, oh(14), 14, 0, "scan_e0"));
        vecs.push_back(mk(1, 1, 2, oh(14), 14, 0, "scan_e1"));
        vecs.push_back(mk(1, 1, 2, oh(14), 14, 0, "scan_e2"));
        vecs.push_back(mk(1, 1, 2, oh(15), 15, 0, "scan_e3"));
        vecs.push_back(mk(1, 1, 2, oh(15), 15, 0, "scan_e4"));
        vecs.push_back(mk(1, 1, 2, oh(15), 15, 0, "scan_e5"));
        vecs.push_back(mk(1, 1, 2, 16'b1000000000000000, 0, 1, "wrap_e6"));
        vecs.push_back(mk(1, 1, 2, oh(0), 0, 0, "scan_e7"));
        vecs.push_back(mk(1, 1, 2, oh(0), 0, 0, "scan_e8"));
        vecs.push_back(mk(1, 1, 2, oh(1), 1, 0, "scan_e9"));
        vecs.push_back(mk(1, 1, 2, oh(1), 1, 0, "scan_e10"));
        vecs.push_back(mk(1, 1, 2, oh(1), 1, 0, "scan_e11"));
        vecs.push_back(mk(1, 1, 2, oh(2), 2, 0, "scan_e12"));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 2, 16'b0, 2, 0, "frozen"));
        vecs.push_back(mk(1, 1, 2, oh(2), 2, 0, "resume1"));
        vecs.push_back(mk(1, 1, 2, oh(2), 2, 0, "resume2"));
        vecs.push_back(mk(1, 1, 2, oh(3), 3, 0, "resume3"));
        vecs.push_back(mk(1, 0, 9, 16'b0000000001000000, 9, 0, "mode_exit"));

        reset = 1'b1;
        enable = 1'b0;
        mode = 1'b0;
        sel = '0;
        #2;
        chk("rst.d", d, '0);
        chk("rst.idx", W'(idx), '0);
        chk("rst.wrap", W'(wrap), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // scan up to a wrap, then reset asynchronously while wrap is high
        step(mk(1, 1, 15, oh(15), 15, 0, "pre_e0"));
        step(mk(1, 1, 15, oh(15), 15, 0, "pre_e1"));
        step(mk(1, 1, 15, oh(15), 15, 0, "pre_e2"));
        step(mk(1, 1, 15, oh(0), 0, 1, "pre_wrap"));
        #2;
        reset = 1'b1;
        #1;
        chk("arst.d", d, '0);
        chk("arst.idx", W'(idx), '0);
        chk("arst.wrap", W'(wrap), '0);
        #1;
        reset = 1'b0;
        step(mk(1, 0, 7, 16'b0000000100000000, 7, 0, "post_rst"));
        step(mk(1, 1, 4, oh(4), 4, 0, "reent_e0"));
        step(mk(1, 1, 9, oh(4), 4, 0, "reent_e1"));
        step(mk(1, 1, 9, oh(4), 4, 0, "reent_e2"));
        step(mk(1, 1, 9, oh(5), 5, 0, "reent_e3"));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
